// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: register bus between a host and the timer controller.
interface timer_ctrl_if;
    logic       sel;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ready;
    modport master(output sel, wr, addr, wdata, input rdata, ready);
    modport slave(input sel, wr, addr, wdata, output rdata, ready);
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: register-mapped controller sequencing an 8-bit timer through IDLE/LOAD/RUN.
module timer_ctrl #(
    parameter logic [7:0] RST_RELOAD = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    timer_ctrl_if.slave       bus,
    output logic              tmr_load,
    output logic              tmr_en,
    output logic              tmr_up_dw,
    output logic [1:0]        tmr_cks,
    output logic [7:0]        tmr_data,
    input  logic [7:0]        tmr_tcnt,
    input  logic              tmr_ovf,
    input  logic              tmr_udf,
    output logic              irq
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    state_t     state, state_nxt;
    logic [5:0] ctrl, ctrl_nxt;
    logic [7:0] reload, rd_mux;
    logic       evt, wr_ctrl, wr_reload, wr_status, ev, stop;
    assign wr_ctrl   = bus.sel & bus.wr & (bus.addr == 2'd0);
    assign wr_reload = bus.sel & bus.wr & (bus.addr == 2'd1);
    assign wr_status = bus.sel & bus.wr & (bus.addr == 2'd2);
    assign ev        = (state == RUN) & (tmr_ovf | tmr_udf);
    assign stop      = wr_ctrl & ~bus.wdata[0];
    assign irq       = evt & ctrl[5];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    // A stop write outranks everything; a start write in RUN restarts via LOAD
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = ctrl_nxt[0] ? LOAD : IDLE;
            LOAD:    state_nxt = stop ? IDLE : RUN;
            RUN:     state_nxt = stop ? IDLE : wr_ctrl ? LOAD : ev ? (ctrl[4] ? LOAD : IDLE) : RUN;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        tmr_load = (state == LOAD);
        tmr_en   = (state == RUN);
        tmr_data = tmr_load ? reload : 8'h00;
    end
    always_comb begin
        ctrl_nxt = wr_ctrl ? bus.wdata[5:0] : ctrl;
        if (ev & ~ctrl[4] & ~wr_ctrl) ctrl_nxt[0] = 1'b0;
        rd_mux = bus.addr == 2'd0 ? {2'b00, ctrl} :
                 bus.addr == 2'd1 ? reload :
                 bus.addr == 2'd2 ? {6'b0, state != IDLE, evt} : tmr_tcnt;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ctrl      <= 6'h00;
            reload    <= RST_RELOAD;
            evt       <= 1'b0;
            tmr_up_dw <= 1'b0;
            tmr_cks   <= 2'b00;
            bus.rdata <= 8'h00;
            bus.ready <= 1'b0;
        end else begin
            ctrl      <= ctrl_nxt;
            evt       <= ev | (evt & ~(wr_status & bus.wdata[0]));
            bus.ready <= bus.sel;
            if (wr_reload) reload <= bus.wdata;
            if (state_nxt == LOAD) {tmr_cks, tmr_up_dw} <= ctrl_nxt[3:1];
            if (bus.sel & ~bus.wr) bus.rdata <= rd_mux;
        end
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: scenario tasks with a read-data scoreboard for timer_ctrl.
module tb_timer_ctrl;
    localparam logic [7:0] RST_RELOAD = 8'hA5;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       tmr_load, tmr_en, tmr_up_dw, irq;
    logic [1:0] tmr_cks;
    logic [7:0] tmr_data;
    logic [7:0] tmr_tcnt = 8'h00;
    logic       tmr_ovf = 1'b0, tmr_udf = 1'b0;
    int         total = 0, bad = 0;
    logic [7:0] rd_q[$];
    logic       rd_due = 1'b0;
    always #5 clk = ~clk;
    timer_ctrl_if bus();
    timer_ctrl #(.RST_RELOAD(RST_RELOAD)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .tmr_load(tmr_load), .tmr_en(tmr_en), .tmr_up_dw(tmr_up_dw), .tmr_cks(tmr_cks),
        .tmr_data(tmr_data), .tmr_tcnt(tmr_tcnt), .tmr_ovf(tmr_ovf), .tmr_udf(tmr_udf), .irq(irq)
    );
    always @(negedge clk)
        if (rd_due) begin
            rd_due = 1'b0;
            total++;
            if (bus.ready !== 1'b1 || bus.rdata !== rd_q[0]) begin
                bad++;
                $display("FAIL read: ready=%b rdata=%h, expected ready=1 rdata=%h", bus.ready, bus.rdata, rd_q[0]);
            end
            void'(rd_q.pop_front());
        end
    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        bus.sel = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        bus.sel = 1'b0; bus.wr = 1'b0;
    endtask
    task automatic rd_reg(input logic [1:0] a, input logic [7:0] exp);
        bus.sel = 1'b1; bus.wr = 1'b0; bus.addr = a;
        rd_q.push_back(exp);
        @(posedge clk); #1;
        bus.sel = 1'b0;
        rd_due = 1'b1;
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic pulse(input logic o, input logic u);
        tmr_ovf = o; tmr_udf = u;
        @(posedge clk); #1;
        tmr_ovf = 1'b0; tmr_udf = 1'b0;
    endtask
    task automatic test_reset;
        #3;
        total++;
        if ({tmr_load, tmr_en, tmr_up_dw, tmr_cks, tmr_data, bus.rdata, bus.ready, irq} !== 23'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want all 0", {tmr_load, tmr_en, tmr_up_dw, tmr_cks, tmr_data, bus.rdata, bus.ready, irq});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(3);
        total++;
        if ({tmr_load, tmr_en} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset: load/en=%b want 00", {tmr_load, tmr_en});
        end
        rd_reg(2'd1, RST_RELOAD);
        rd_reg(2'd0, 8'h00);
        rd_reg(2'd2, 8'h00);
    endtask
    task automatic test_basic_start;
        wr_reg(2'd1, 8'h10);
        wr_reg(2'd0, 8'h01);
        total++;
        if ({tmr_load, tmr_en, tmr_data} !== {1'b1, 1'b0, 8'h10}) begin
            bad++;
            $display("FAIL start_load: load/en/data=%b/%b/%h want 1/0/10", tmr_load, tmr_en, tmr_data);
        end
        tick(1);
        total++;
        if ({tmr_load, tmr_en} !== 2'b01) begin
            bad++;
            $display("FAIL start_run: load/en=%b want 01", {tmr_load, tmr_en});
        end
        rd_reg(2'd2, 8'h02);
        wr_reg(2'd0, 8'h00);
        total++;
        if (tmr_en !== 1'b0) begin
            bad++;
            $display("FAIL stop_write: en=%b want 0", tmr_en);
        end
        total++;
        if (bus.rdata !== 8'h02) begin
            bad++;
            $display("FAIL rdata_hold: rdata=%h want 02", bus.rdata);
        end
        rd_reg(2'd2, 8'h00);
    endtask
    task automatic test_oneshot;
        pulse(1'b1, 1'b0);
        rd_reg(2'd2, 8'h00);
        wr_reg(2'd1, 8'hFE);
        wr_reg(2'd0, 8'h21);
        pulse(1'b1, 1'b0);
        total++;
        if ({tmr_en, irq} !== 2'b10) begin
            bad++;
            $display("FAIL ovf_in_load: en/irq=%b want 10", {tmr_en, irq});
        end
        pulse(1'b1, 1'b0);
        total++;
        if ({tmr_en, tmr_load, irq} !== 3'b001) begin
            bad++;
            $display("FAIL oneshot_ovf: en/load/irq=%b want 001", {tmr_en, tmr_load, irq});
        end
        rd_reg(2'd2, 8'h01);
        rd_reg(2'd0, 8'h20);
        wr_reg(2'd2, 8'h01);
        total++;
        if ({irq, bus.rdata} !== {1'b0, 8'h20}) begin
            bad++;
            $display("FAIL evt_clear: irq/rdata=%b/%h want 0/20", irq, bus.rdata);
        end
    endtask
    task automatic test_autoreload;
        wr_reg(2'd1, 8'h02);
        wr_reg(2'd0, 8'h13);
        total++;
        if ({tmr_load, tmr_up_dw, tmr_data} !== {1'b1, 1'b1, 8'h02}) begin
            bad++;
            $display("FAIL ar_load: load/up_dw/data=%b/%b/%h want 1/1/02", tmr_load, tmr_up_dw, tmr_data);
        end
        tick(1);
        pulse(1'b0, 1'b1);
        total++;
        if ({tmr_load, tmr_en, tmr_data} !== {1'b1, 1'b0, 8'h02}) begin
            bad++;
            $display("FAIL ar_reload1: load/en/data=%b/%b/%h want 1/0/02", tmr_load, tmr_en, tmr_data);
        end
        tick(1);
        total++;
        if (tmr_en !== 1'b1) begin
            bad++;
            $display("FAIL ar_resume: en=%b want 1", tmr_en);
        end
        wr_reg(2'd1, 8'h07);
        pulse(1'b0, 1'b1);
        total++;
        if ({tmr_load, tmr_data} !== {1'b1, 8'h07}) begin
            bad++;
            $display("FAIL ar_reload2: load/data=%b/%h want 1/07", tmr_load, tmr_data);
        end
        tick(1);
        rd_reg(2'd2, 8'h03);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL ar_irq_masked: irq=%b want 0", irq);
        end
        wr_reg(2'd0, 8'h00);
        wr_reg(2'd2, 8'h01);
        rd_reg(2'd2, 8'h00);
    endtask
    task automatic test_collision;
        wr_reg(2'd0, 8'h01);
        tick(1);
        bus.sel = 1'b1; bus.wr = 1'b1; bus.addr = 2'd0; bus.wdata = 8'h00; tmr_ovf = 1'b1;
        @(posedge clk); #1;
        bus.sel = 1'b0; bus.wr = 1'b0; tmr_ovf = 1'b0;
        total++;
        if ({tmr_en, tmr_load} !== 2'b00) begin
            bad++;
            $display("FAIL stop_vs_evt: en/load=%b want 00", {tmr_en, tmr_load});
        end
        rd_reg(2'd2, 8'h01);
        wr_reg(2'd0, 8'h01);
        tick(1);
        bus.sel = 1'b1; bus.wr = 1'b1; bus.addr = 2'd2; bus.wdata = 8'h01; tmr_udf = 1'b1;
        @(posedge clk); #1;
        bus.sel = 1'b0; bus.wr = 1'b0; tmr_udf = 1'b0;
        rd_reg(2'd2, 8'h01);
        wr_reg(2'd2, 8'h01);
        rd_reg(2'd2, 8'h00);
    endtask
    task automatic test_shadow;
        wr_reg(2'd0, 8'h03);
        wr_reg(2'd0, 8'h0D);
        tick(2);
        total++;
        if ({tmr_en, tmr_up_dw, tmr_cks} !== 4'b1100) begin
            bad++;
            $display("FAIL shadow_hold: en/up_dw/cks=%b/%b/%b want 1/1/00", tmr_en, tmr_up_dw, tmr_cks);
        end
        wr_reg(2'd0, 8'h0D);
        total++;
        if ({tmr_load, tmr_up_dw, tmr_cks} !== 4'b1011) begin
            bad++;
            $display("FAIL shadow_update: load/up_dw/cks=%b/%b/%b want 1/0/11", tmr_load, tmr_up_dw, tmr_cks);
        end
        rd_reg(2'd0, 8'h0D);
        wr_reg(2'd0, 8'h00);
    endtask
    task automatic test_reset_mid_run;
        wr_reg(2'd0, 8'h3B);
        tick(1);
        pulse(1'b1, 1'b0);
        tick(1);
        total++;
        if ({irq, tmr_en, tmr_up_dw, tmr_cks} !== 5'b11110) begin
            bad++;
            $display("FAIL pre_reset_run: irq/en/up_dw/cks=%b want 11110", {irq, tmr_en, tmr_up_dw, tmr_cks});
        end
        tmr_tcnt = 8'h5A;
        rd_reg(2'd3, 8'h5A);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({tmr_load, tmr_en, tmr_up_dw, tmr_cks, tmr_data, bus.rdata, bus.ready, irq} !== 23'd0) begin
            bad++;
            $display("FAIL async_reset: got %b want all 0", {tmr_load, tmr_en, tmr_up_dw, tmr_cks, tmr_data, bus.rdata, bus.ready, irq});
        end
        #4;
        rst_n = 1'b1;
        rd_reg(2'd1, RST_RELOAD);
        tmr_tcnt = 8'h3C;
        rd_reg(2'd3, 8'h3C);
        rd_reg(2'd2, 8'h00);
        rd_reg(2'd0, 8'h00);
    endtask
    initial begin
        bus.sel = 1'b0; bus.wr = 1'b0; bus.addr = 2'd0; bus.wdata = 8'h00;
        test_reset;
        test_basic_start;
        test_oneshot;
        test_autoreload;
        test_collision;
        test_shadow;
        test_reset_mid_run;
        tick(2);
        total++;
        if (rd_q.size() != 0) begin
            bad++;
            $display("FAIL read_drain: %0d reads outstanding want 0", rd_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1, "watchdog");
    end
endmodule
